// File: rtl/cplx_acc_dump_pkg.sv
// Shared state type and default widths for the complex frame accumulator.
package cplx_acc_pkg;

  localparam int IN_W  = 33;
  localparam int ACC_W = IN_W + 8;
  localparam int OUT_W = 16;

  typedef enum logic {
    ACC  = 1'b0,
    DUMP = 1'b1
  } state_t;

endpackage

// File: rtl/cplx_acc_dump_if.sv
// Sample/result handshake bundle between the complex multiplier, the accumulator and its consumer.
interface cplx_acc_dump_if #(
  parameter int IN_W  = cplx_acc_pkg::IN_W,
  parameter int OUT_W = cplx_acc_pkg::OUT_W
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_pr;
  logic signed [IN_W-1:0]  in_pi;
  logic [7:0]              len;
  logic [4:0]              shift;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_re;
  logic signed [OUT_W-1:0] out_im;
  logic                    out_sat;

  modport master (
    output in_valid, in_pr, in_pi, len, shift, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_sat
  );

  modport slave (
    input  in_valid, in_pr, in_pi, len, shift, out_ready,
    output in_ready, out_valid, out_re, out_im, out_sat
  );

endinterface

// File: rtl/cplx_acc_dump_round_sat.sv
// Round-half-up arithmetic right shift of a frame sum, then clip to the signed output range.
module cplx_round_sat #(
  parameter int ACC_W = cplx_acc_pkg::ACC_W,
  parameter int OUT_W = cplx_acc_pkg::OUT_W
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic [4:0]              shift_i,
  output logic signed [OUT_W-1:0] val_o,
  output logic                    clip_o
);

  localparam int EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rnd;
  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] shifted;

  // One extra guard bit keeps the rounding add from wrapping a full-scale sum.
  always_comb begin
    ext = {acc_i[ACC_W-1], acc_i};
    rnd = '0;
    if (shift_i != 5'd0) begin
      rnd = EXT_W'(1) << (shift_i - 5'd1);
    end
    sum = ext + rnd;
    if (int'(shift_i) >= ACC_W) begin
      shifted = ext[EXT_W-1] ? '1 : '0;
    end else begin
      shifted = sum >>> shift_i;
    end
  end

  always_comb begin
    val_o  = shifted[OUT_W-1:0];
    clip_o = 1'b0;
    if (shifted > MAX_V) begin
      val_o  = MAX_V[OUT_W-1:0];
      clip_o = 1'b1;
    end else if (shifted < MIN_V) begin
      val_o  = MIN_V[OUT_W-1:0];
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/cplx_acc_dump.sv
// Accumulates len+1 complex products per frame, then holds one rounded, saturated result until taken.
module cplx_acc_dump #(
  parameter int IN_W  = cplx_acc_pkg::IN_W,
  parameter int ACC_W = IN_W + 8,
  parameter int OUT_W = cplx_acc_pkg::OUT_W
) (
  input logic            clk,
  input logic            rst_n,
  cplx_acc_dump_if.slave bus
);

  import cplx_acc_pkg::*;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0] acc_im_q, acc_im_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              len_q, len_d;
  logic [4:0]              shift_q, shift_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_re_q, out_re_d;
  logic signed [OUT_W-1:0] out_im_q, out_im_d;
  logic                    out_sat_q, out_sat_d;

  logic                    accept;
  logic                    last;
  logic                    load_out;
  logic                    out_fire;
  logic [7:0]              frame_len;
  logic signed [OUT_W-1:0] rs_re, rs_im;
  logic                    clip_re, clip_im;

  // The first sample of a frame compares against the live len, later ones against the latched copy.
  assign accept    = bus.in_valid && (state_q == ACC);
  assign frame_len = (cnt_q == 8'd0) ? bus.len : len_q;
  assign last      = accept && (cnt_q == frame_len);
  assign load_out  = (state_q == DUMP) && !out_valid_q;
  assign out_fire  = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:     if (last)     state_d = DUMP;
      DUMP:    if (out_fire) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ACC);
    bus.out_valid = out_valid_q;
    bus.out_re    = out_re_q;
    bus.out_im    = out_im_q;
    bus.out_sat   = out_sat_q;
  end

  cplx_round_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_rs_re (
    .acc_i   (acc_re_q),
    .shift_i (shift_q),
    .val_o   (rs_re),
    .clip_o  (clip_re)
  );

  cplx_round_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_rs_im (
    .acc_i   (acc_im_q),
    .shift_i (shift_q),
    .val_o   (rs_im),
    .clip_o  (clip_im)
  );

  // The result is registered one cycle after the final accept, once the sums have settled.
  always_comb begin
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_sat_d   = out_sat_q;
    if (accept) begin
      acc_re_d = acc_re_q + {{(ACC_W-IN_W){bus.in_pr[IN_W-1]}}, bus.in_pr};
      acc_im_d = acc_im_q + {{(ACC_W-IN_W){bus.in_pi[IN_W-1]}}, bus.in_pi};
      cnt_d    = cnt_q + 8'd1;
      if (cnt_q == 8'd0) len_d = bus.len;
      if (last) shift_d = bus.shift;
    end
    if (load_out) begin
      out_valid_d = 1'b1;
      out_re_d    = rs_re;
      out_im_d    = rs_im;
      out_sat_d   = clip_re | clip_im;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
      acc_re_d    = '0;
      acc_im_d    = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_cplx_acc_dump.sv
// Directed checks of the complex frame accumulator: single-sample vector table plus multi-cycle sequences.
module tb_cplx_acc_dump;

  typedef struct {
    longint     pr;
    longint     pi;
    logic [4:0] sh;
    longint     expRe;
    longint     expIm;
    longint     expSat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;
  vec_t vecs[8];

  cplx_acc_dump_if bus ();

  cplx_acc_dump dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic checkResult(input string name, input longint re, input longint im, input longint sat);
    checkOutput({name, "_re"}, bus.out_re, re);
    checkOutput({name, "_im"}, bus.out_im, im);
    checkOutput({name, "_sat"}, bus.out_sat, sat);
  endtask

  // Drives one sample, waiting (bounded) for in_ready; returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input longint pr, input longint pi, input logic [7:0] l, input logic [4:0] s);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) checkOutput("in_ready_timeout", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_pr    = pr[32:0];
    bus.in_pi    = pi[32:0];
    bus.len      = l;
    bus.shift    = s;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic popOutput(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({name, "_drop"}, bus.out_valid, 0);
    checkOutput({name, "_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    vecs[0] = '{40000, -40000, 5'd0, 32767, -32768, 1};
    vecs[1] = '{6, -6, 5'd2, 2, -1, 0};
    vecs[2] = '{5, 0, 5'd2, 1, 0, 0};
    vecs[3] = '{-5, 7, 5'd1, -2, 4, 0};
    vecs[4] = '{32767, -32768, 5'd0, 32767, -32768, 0};
    vecs[5] = '{32768, -32769, 5'd0, 32767, -32768, 1};
    vecs[6] = '{65535, 3, 5'd1, 32767, 2, 1};
    vecs[7] = '{-64'sd4294967296, 64'sd4294967295, 5'd31, -2, 2, 0};

    bus.in_valid  = 1'b0;
    bus.in_pr     = '0;
    bus.in_pi     = '0;
    bus.len       = '0;
    bus.shift     = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkResult("rst", 0, 0, 0);

    // Single-sample frames from the table, each with exact one-cycle latency
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].pr, vecs[i].pi, 8'd0, vecs[i].sh);
      checkOutput($sformatf("vec%0d_lat0", i), bus.out_valid, 0);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_lat1", i), bus.out_valid, 1);
      checkResult($sformatf("vec%0d", i), vecs[i].expRe, vecs[i].expIm, vecs[i].expSat);
      popOutput($sformatf("vec%0d", i));
    end

    // Five-sample frame; len and shift wiggle mid-frame, only the first len and last shift count
    applyStimulus(5, 0, 8'd4, 5'd3);
    applyStimulus(4, 0, 8'd0, 5'd3);
    applyStimulus(9, 0, 8'd0, 5'd3);
    applyStimulus(16, 0, 8'd1, 5'd3);
    checkOutput("f5_not_early", bus.in_ready, 1);
    applyStimulus(25, 0, 8'd0, 5'd0);
    checkOutput("f5_lat0", bus.out_valid, 0);
    checkOutput("f5_busy", bus.in_ready, 0);
    @(posedge clk); #1;
    checkOutput("f5_lat1", bus.out_valid, 1);
    checkResult("f5", 59, 0, 0);
    popOutput("f5");

    // Back-pressure with in_valid held high during DUMP
    applyStimulus(10, -1, 8'd1, 5'd0);
    applyStimulus(20, -2, 8'd1, 5'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_pr    = 33'sd100;
    bus.in_pi    = 33'sd100;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d_valid", c), bus.out_valid, 1);
      checkOutput($sformatf("bp%0d_in_ready", c), bus.in_ready, 0);
      checkResult($sformatf("bp%0d", c), 30, -3, 0);
    end
    bus.in_valid = 1'b0;
    popOutput("bp");
    checkResult("bp_hold", 30, -3, 0);
    applyStimulus(3, 1, 8'd0, 5'd0);
    @(posedge clk); #1;
    checkOutput("bp_next_valid", bus.out_valid, 1);
    checkResult("bp_next", 3, 1, 0);
    popOutput("bp_next");

    // Reset mid-frame discards the partial sum
    applyStimulus(1, 0, 8'd3, 5'd0);
    applyStimulus(2, 0, 8'd3, 5'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("abort_valid", bus.out_valid, 0);
    checkOutput("abort_ready", bus.in_ready, 1);
    applyStimulus(7, 0, 8'd0, 5'd0);
    @(posedge clk); #1;
    checkOutput("abort_next_valid", bus.out_valid, 1);
    checkResult("abort_next", 7, 0, 0);
    popOutput("abort_next");

    // Reset mid-DUMP drops the pending result
    applyStimulus(9, 9, 8'd0, 5'd0);
    @(posedge clk); #1;
    checkOutput("dumprst_pre", bus.out_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("dumprst_valid", bus.out_valid, 0);
    checkResult("dumprst", 0, 0, 0);
    applyStimulus(4, -4, 8'd0, 5'd0);
    @(posedge clk); #1;
    checkOutput("dumprst_next_valid", bus.out_valid, 1);
    checkResult("dumprst_next", 4, -4, 0);
    popOutput("dumprst_next");

    // 256 full-scale samples: no accumulator wrap, both components clip
    for (int i = 0; i < 256; i++) begin
      if (i == 255) checkOutput("full_pre_last", bus.in_ready, 1);
      applyStimulus(64'sd4294967295, -64'sd4294967296, 8'd255, 5'd8);
    end
    @(posedge clk); #1;
    checkOutput("full_valid", bus.out_valid, 1);
    checkResult("full", 32767, -32768, 1);
    popOutput("full");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cplx_acc_dump.md
CPLX_ACC_DUMP -- requirements
Module: cplx_acc_dump

Interface
REQ-001 Parameters (name, default, meaning): IN_W, 33, signed width of incoming complex product components.
REQ-002 Parameter ACC_W, IN_W+8, accumulator width; supports 256 full-scale samples without overflow.
REQ-003 Parameter OUT_W, 16, signed width of output components.
REQ-004 Ports (name, direction, width, meaning): clk, in, 1, single clock, rising edge; rst_n, in, 1, reset, synchronous and active-low.
REQ-005 Ports in_valid (in, 1) and in_ready (out, 1) SHALL form the input handshake; a sample is accepted when both are high at a rising edge.
REQ-006 Ports in_pr and in_pi (in, IN_W each) SHALL carry the signed real and imaginary product from the upstream complex multiplier.
REQ-007 Port len (in, 8) SHALL give frame length minus 1, i.e. 1..256 samples.
REQ-008 Port shift (in, 5) SHALL give the arithmetic right-shift applied at dump.
REQ-009 Ports out_valid (out, 1) and out_ready (in, 1) SHALL form the output handshake.
REQ-010 Ports out_re and out_im (out, OUT_W each) SHALL carry the signed scaled frame sums.
REQ-011 Port out_sat (out, 1) SHALL be high when either output component was clipped.

Function
REQ-012 The block SHALL have two states, ACC and DUMP; in_ready = (state==ACC).
REQ-013 In ACC, each accepted sample SHALL add sign-extended in_pr/in_pi to acc_re/acc_im and increment cnt.
REQ-014 len SHALL be latched when the first sample of a frame is accepted (cnt==0); later len changes within the frame SHALL be ignored.
REQ-015 A frame length of len+1 SHALL be used; len=0 SHALL give single-sample frames.
REQ-016 When an accepted sample has cnt==latched len, the state SHALL go to DUMP; out_valid SHALL rise on the next edge (1-cycle latency from the last accepted sample).
REQ-017 Out_re/out_im SHALL equal sat(((acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift)) using round-half-up.
REQ-018 shift SHALL be sampled with the last sample; shift values of ACC_W or more SHALL yield 0 or -1 per sign.
REQ-019 Saturation SHALL clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and out_sat = clip_re | clip_im.
REQ-020 In DUMP, out_valid, out_re, out_im and out_sat SHALL remain stable until out_valid&&out_ready.
REQ-021 In DUMP, in_valid SHALL be ignored (no accept, no acc change).
REQ-022 On the output handshake, the block SHALL clear acc and cnt, drop out_valid on that edge, and return to ACC; the next sample SHALL be accepted on the following edge.
REQ-023 Out_re/out_im SHALL hold their last values after the handshake; only out_valid qualifies them.

Reset
REQ-024 rst_n low at a rising edge SHALL set state=ACC, acc_re=acc_im=0, cnt=0, latched len=0, out_valid=0, out_re=out_im=0, out_sat=0.
REQ-025 Reset mid-frame or mid-DUMP SHALL discard partial sums and any pending output without emitting it.
REQ-026 in_ready SHALL be 1 on the first cycle after rst_n is deasserted.

Structure
REQ-027 Package cplx_acc_pkg SHALL hold the state enum (ACC, DUMP) and the default width constants IN_W, ACC_W and OUT_W.
REQ-028 Sub-module cplx_round_sat (ACC_W in, OUT_W out, shift, clip flag) SHALL perform rounding and saturation, instantiated once for re and once for im.

Verification
REQ-029 len=4, shift=0, samples pr=5,4,9,16,25 with pi=0 -> out_re=59, out_im=0, out_sat=0, out_valid one cycle after the 5th accept.
REQ-030 len=0, in_pr=40000, in_pi=-40000, shift=0 -> out_re=32767, out_im=-32768, out_sat=1.
REQ-031 len=0, shift=2: pr=6 -> out_re=2; pr=-6 -> out_re=-1; pr=5 -> out_re=1.
REQ-032 out_ready=0 for 3 cycles after out_valid, with in_valid=1 and pr=100 -> outputs stable, in_ready=0, the next frame sum excludes the ignored samples.
REQ-033 Frame len=3 with 2 samples accepted, then rst_n=0 for 1 cycle, then len=0 and pr=7 -> single output out_re=7, with no output from the aborted frame.
REQ-034 len=255, 256 samples of pr=2^32-1, shift=8 -> no accumulator overflow; out_re saturates to 32767 with out_sat=1.
